tick_gen_multi: RTL and testbench

Multi-channel, parametrised rate divider for game timing: car movement steps, obstacle spawn intervals, score and animation ticks. Each channel holds its own loadable period and produces one-cycle tick pulses in either periodic or one-shot mode. Channels have independent enable, load and clear controls. It replaces single fixed-width free-running dividers and gives the game FSM and the VGA draw logic a single timing source.

---
 rtl/tick_gen_multi.sv | 101 ++++++++++
 tb/tb_tick_gen_multi.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_gen_multi.sv
// tick_gen_multi: NCH independent loadable tick dividers, periodic or one-shot.
// Define TICK_GEN_PRESCALE_EN to add a shared PRESCALE divider gating every channel's advance.
module tick_gen_multi #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned WIDTH    = 27,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic [NCH*WIDTH-1:0] period,
  input  logic [NCH-1:0]       mode,
  input  logic [NCH-1:0]       load,
  input  logic [NCH-1:0]       clear,
  input  logic [NCH-1:0]       enable,
  output logic [NCH-1:0]       tick,
  output logic [NCH-1:0]       busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e           st_q  [NCH];
  state_e           st_d  [NCH];
  logic [WIDTH-1:0] cnt_q [NCH];
  logic [WIDTH-1:0] cnt_d [NCH];
  logic [WIDTH-1:0] per_q [NCH];
  logic [WIDTH-1:0] per_d [NCH];
  logic [NCH-1:0]   md_q, md_d;
  logic [NCH-1:0]   tick_q, tick_d;
  logic             ce;

`ifdef TICK_GEN_PRESCALE_EN
  localparam int unsigned   PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  always_comb begin
    ce    = (pre_q == PMAX);
    pre_d = ce ? '0 : pre_q + PW'(1);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) pre_q <= '0;
    else         pre_q <= pre_d;
  end
`else
  // Always 1 for any legal PRESCALE; the ratio has no effect without the prescaler.
  assign ce = (PRESCALE >= 1);
`endif

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    per_d  = per_q;
    md_d   = md_q;
    tick_d = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (clear[i]) begin
        st_d[i]  = IDLE;
        cnt_d[i] = '0;
      end else if (load[i]) begin
        per_d[i] = period[i*WIDTH +: WIDTH];
        cnt_d[i] = period[i*WIDTH +: WIDTH];
        md_d[i]  = mode[i];
        st_d[i]  = RUN;
      end else if (st_q[i] == RUN && enable[i] && ce) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - WIDTH'(1);
        end else begin
          tick_d[i] = 1'b1;
          if (md_q[i]) st_d[i]  = IDLE;
          else         cnt_d[i] = per_q[i];
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        st_q[i]  <= IDLE;
        cnt_q[i] <= '0;
        per_q[i] <= '0;
      end
      md_q   <= '0;
      tick_q <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      md_q   <= md_d;
      tick_q <= tick_d;
    end
  end

  always_comb begin
    tick = tick_q;
    for (int unsigned i = 0; i < NCH; i++) busy[i] = (st_q[i] == RUN);
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed bench for tick_gen_multi: reset, periodic, one-shot, enable pause, collisions, multi-channel.
module tb_tick_gen_multi;
  localparam int unsigned NCH      = 4;
  localparam int unsigned WIDTH    = 27;
  localparam int unsigned PRESCALE = 5;

  logic                 CLOCK_50 = 1'b0;
  logic                 resetn;
  logic [NCH*WIDTH-1:0] period;
  logic [NCH-1:0]       mode, load, clear, enable;
  logic [NCH-1:0]       tick, busy;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  tick_gen_multi #(.NCH(NCH), .WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .period   (period),
    .mode     (mode),
    .load     (load),
    .clear    (clear),
    .enable   (enable),
    .tick     (tick),
    .busy     (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_period(input int unsigned ch, input int unsigned val);
    period[ch*WIDTH +: WIDTH] = WIDTH'(val);
  endtask

  task automatic test_reset();
    resetn = 1'b0; period = '0; mode = '0; load = '0; clear = '0; enable = '0;
    #12;
    n_total++;
    if (tick !== 4'b0000) $display("FAIL reset_tick: got %b expected %b", tick, 4'b0000);
    else n_pass++;
    n_total++;
    if (busy !== 4'b0000) $display("FAIL reset_busy: got %b expected %b", busy, 4'b0000);
    else n_pass++;
    @(negedge CLOCK_50);
    resetn = 1'b1;
    enable = '1;
    repeat (5) @(negedge CLOCK_50);
    n_total++;
    if ((busy | tick) !== 4'b0000) $display("FAIL idle_after_reset: got busy=%b tick=%b expected 0000", busy, tick);
    else n_pass++;
  endtask

  task automatic test_periodic();
    @(negedge CLOCK_50);
    set_period(0, 3); mode[0] = 1'b0; load[0] = 1'b1;
    @(negedge CLOCK_50);
    load[0] = 1'b0;
    set_period(0, 7);
    n_total++;
    if (busy[0] !== 1'b1) $display("FAIL periodic_busy_k0: got %b expected 1", busy[0]);
    else n_pass++;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLOCK_50);
      n_total++;
      if (tick[0] !== (k % 4 == 0)) $display("FAIL periodic_tick k=%0d: got %b expected %b", k, tick[0], (k % 4 == 0));
      else n_pass++;
      n_total++;
      if (busy[0] !== 1'b1) $display("FAIL periodic_busy k=%0d: got %b expected 1", k, busy[0]);
      else n_pass++;
    end
    clear[0] = 1'b1;
    @(negedge CLOCK_50);
    clear[0] = 1'b0;
    n_total++;
    if (busy[0] !== 1'b0) $display("FAIL clear_busy: got %b expected 0", busy[0]);
    else n_pass++;
  endtask

  task automatic test_oneshot();
    int unsigned strays;
    @(negedge CLOCK_50);
    set_period(1, 5); mode[1] = 1'b1; load[1] = 1'b1;
    @(negedge CLOCK_50);
    load[1] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLOCK_50);
      n_total++;
      if (tick[1] !== (k == 6)) $display("FAIL oneshot_tick k=%0d: got %b expected %b", k, tick[1], (k == 6));
      else n_pass++;
      n_total++;
      if (busy[1] !== (k < 6)) $display("FAIL oneshot_busy k=%0d: got %b expected %b", k, busy[1], (k < 6));
      else n_pass++;
    end
    strays = 0;
    repeat (50) begin
      @(negedge CLOCK_50);
      if (tick[1] !== 1'b0 || busy[1] !== 1'b0) strays++;
    end
    n_total++;
    if (strays !== 0) $display("FAIL oneshot_quiet: got %0d active cycles expected 0", strays);
    else n_pass++;
    mode[1] = 1'b0;
  endtask

  task automatic test_enable_pause();
    @(negedge CLOCK_50);
    set_period(0, 9); mode[0] = 1'b0; load[0] = 1'b1;
    @(negedge CLOCK_50);
    load[0] = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge CLOCK_50);
      n_total++;
      if (tick[0] !== (k == 17)) $display("FAIL pause_tick k=%0d: got %b expected %b", k, tick[0], (k == 17));
      else n_pass++;
      if (k == 4)  enable[0] = 1'b0;
      if (k == 11) enable[0] = 1'b1;
    end
    clear[0] = 1'b1;
    @(negedge CLOCK_50);
    clear[0] = 1'b0;
  endtask

  task automatic test_collisions();
    int unsigned strays;
    @(negedge CLOCK_50);
    set_period(2, 2); mode[2] = 1'b0; load[2] = 1'b1;
    @(negedge CLOCK_50);
    load[2] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLOCK_50);
      n_total++;
      if (tick[2] !== (k == 8)) $display("FAIL load_on_expiry k=%0d: got %b expected %b", k, tick[2], (k == 8));
      else n_pass++;
      n_total++;
      if (busy[2] !== 1'b1) $display("FAIL load_on_expiry_busy k=%0d: got %b expected 1", k, busy[2]);
      else n_pass++;
      if (k == 2) begin set_period(2, 4); load[2] = 1'b1; end
      if (k == 3) load[2] = 1'b0;
    end
    set_period(2, 1); clear[2] = 1'b1; load[2] = 1'b1;
    @(negedge CLOCK_50);
    clear[2] = 1'b0; load[2] = 1'b0;
    n_total++;
    if (busy[2] !== 1'b0) $display("FAIL clear_load_busy: got %b expected 0", busy[2]);
    else n_pass++;
    strays = 0;
    repeat (8) begin
      @(negedge CLOCK_50);
      if (tick[2] !== 1'b0 || busy[2] !== 1'b0) strays++;
    end
    n_total++;
    if (strays !== 0) $display("FAIL clear_load_quiet: got %0d active cycles expected 0", strays);
    else n_pass++;
  endtask

  task automatic test_multi();
    logic [3:0]  exp;
    int unsigned strays;
    @(negedge CLOCK_50);
    clear = '1;
    @(negedge CLOCK_50);
    clear = '0;
    for (int i = 0; i < 4; i++) set_period(i, i);
    mode = '0; load = '1;
    @(negedge CLOCK_50);
    load = '0;
    n_total++;
    if (busy !== 4'b1111) $display("FAIL multi_busy_k0: got %b expected %b", busy, 4'b1111);
    else n_pass++;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLOCK_50);
      for (int i = 0; i < 4; i++) exp[i] = (k % (i + 1) == 0);
      n_total++;
      if (tick !== exp) $display("FAIL multi_tick k=%0d: got %b expected %b", k, tick, exp);
      else n_pass++;
    end
    #2 resetn = 1'b0;
    #1;
    n_total++;
    if ((tick | busy) !== 4'b0000) $display("FAIL async_reset: got tick=%b busy=%b expected 0000", tick, busy);
    else n_pass++;
    @(negedge CLOCK_50);
    resetn = 1'b1;
    strays = 0;
    repeat (6) begin
      @(negedge CLOCK_50);
      if ((tick | busy) !== 4'b0000) strays++;
    end
    n_total++;
    if (strays !== 0) $display("FAIL idle_after_midrun_reset: got %0d active cycles expected 0", strays);
    else n_pass++;
  endtask

`ifdef TICK_GEN_PRESCALE_EN
  task automatic test_prescale();
    int unsigned waited;
    @(negedge CLOCK_50);
    set_period(0, 1); mode[0] = 1'b0; load[0] = 1'b1;
    @(negedge CLOCK_50);
    load[0] = 1'b0;
    n_total++;
    if (busy[0] !== 1'b1) $display("FAIL prescale_busy: got %b expected 1", busy[0]);
    else n_pass++;
    waited = 0;
    while (tick[0] !== 1'b1 && waited < 30) begin
      @(negedge CLOCK_50);
      waited++;
    end
    n_total++;
    if (tick[0] !== 1'b1) $display("FAIL prescale_first_tick: got no tick in %0d cycles expected one", waited);
    else n_pass++;
    waited = 0;
    do begin
      @(negedge CLOCK_50);
      waited++;
    end while (tick[0] !== 1'b1 && waited < 30);
    n_total++;
    if (waited !== 10) $display("FAIL prescale_interval: got %0d cycles expected 10", waited);
    else n_pass++;
    clear[0] = 1'b1;
    @(negedge CLOCK_50);
    clear[0] = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_enable_pause();
    test_collisions();
    test_multi();
`ifdef TICK_GEN_PRESCALE_EN
    enable = '1;
    test_prescale();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
